// File: rtl/pong_display_pkg.sv
// Shared types and constants for the Pong score display path.
package pong_display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIG_IDX_W  = 2;
  localparam int unsigned DIGIT_W    = 4;

  localparam int unsigned DIG_P1_ONES = 0;
  localparam int unsigned DIG_P1_TENS = 1;
  localparam int unsigned DIG_P2_ONES = 2;
  localparam int unsigned DIG_P2_TENS = 3;

  localparam logic [DIGIT_W-1:0] BLANK_CODE_DEFAULT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } disp_state_e;

endpackage

// File: rtl/score_bcd_split.sv
// Saturating loader plus one repeated-subtract-by-10 step per cycle,
// splitting a binary score into tens and ones.
module score_bcd_split
  import pong_display_pkg::*;
#(
  parameter int unsigned SCORE_W   = 7,
  parameter int unsigned SCORE_MAX = 99
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [SCORE_W-1:0] score,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               ready
);

  logic [SCORE_W-1:0] rem;
  logic [SCORE_W-1:0] rem_sat_c;
  logic [SCORE_W-1:0] rem_sub_c;

  always_comb begin
    rem_sat_c = (score > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : score;
    rem_sub_c = rem - SCORE_W'(10);
  end

  // ready is registered alongside the remainder it describes
  always_ff @(posedge clock) begin
    if (!reset) begin
      rem   <= '0;
      tens  <= '0;
      ready <= 1'b1;
    end else if (load) begin
      rem   <= rem_sat_c;
      tens  <= '0;
      ready <= (rem_sat_c < SCORE_W'(10));
    end else if (step && !ready) begin
      rem   <= rem_sub_c;
      tens  <= tens + DIGIT_W'(1);
      ready <= (rem_sub_c < SCORE_W'(10));
    end
  end

  assign ones = DIGIT_W'(rem);

endmodule

// File: rtl/score_display_ctrl.sv
// Converts two scores to decimal and writes the four digit drivers one at a
// time over a shared value bus with setup/strobe/hold spacing.
module score_display_ctrl
  import pong_display_pkg::*;
#(
  parameter int unsigned        SCORE_W       = 7,
  parameter int unsigned        SCORE_MAX     = 99,
  parameter int unsigned        BLANK_LEADING = 0,
  parameter logic [DIGIT_W-1:0] BLANK_CODE    = BLANK_CODE_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  score_valid,
  input  logic [SCORE_W-1:0]    score_p1,
  input  logic [SCORE_W-1:0]    score_p2,
  output logic [DIGIT_W-1:0]    digit_value,
  output logic [NUM_DIGITS-1:0] digit_update,
  output logic                  busy,
  output logic                  done
);

  disp_state_e           state, state_nxt;
  logic [DIG_IDX_W-1:0]  idx, idx_nxt, idx_inc_c;
  logic [DIGIT_W-1:0]    value_nxt;
  logic [NUM_DIGITS-1:0] update_nxt;
  logic                  busy_nxt, done_nxt;

  logic                  pend_valid, pend_valid_nxt;
  logic [SCORE_W-1:0]    pend_p1, pend_p1_nxt;
  logic [SCORE_W-1:0]    pend_p2, pend_p2_nxt;

  logic                  load_c, convert_c;
  logic [SCORE_W-1:0]    load_p1_c, load_p2_c;

  logic [DIGIT_W-1:0]    p1_tens, p1_ones, p2_tens, p2_ones;
  logic                  p1_ready, p2_ready;
  logic [DIGIT_W-1:0]    digit_c [NUM_DIGITS];

  score_bcd_split #(.SCORE_W(SCORE_W), .SCORE_MAX(SCORE_MAX)) u_split_p1 (
    .clock (clock),
    .reset (reset),
    .load  (load_c),
    .step  (convert_c),
    .score (load_p1_c),
    .tens  (p1_tens),
    .ones  (p1_ones),
    .ready (p1_ready)
  );

  score_bcd_split #(.SCORE_W(SCORE_W), .SCORE_MAX(SCORE_MAX)) u_split_p2 (
    .clock (clock),
    .reset (reset),
    .load  (load_c),
    .step  (convert_c),
    .score (load_p2_c),
    .tens  (p2_tens),
    .ones  (p2_ones),
    .ready (p2_ready)
  );

  // Digit table in strobe order, with optional leading-zero blanking
  always_comb begin
    digit_c[DIG_P1_ONES] = p1_ones;
    digit_c[DIG_P1_TENS] = p1_tens;
    digit_c[DIG_P2_ONES] = p2_ones;
    digit_c[DIG_P2_TENS] = p2_tens;
    if (BLANK_LEADING != 0) begin
      if (p1_tens == '0) digit_c[DIG_P1_TENS] = BLANK_CODE;
      if (p2_tens == '0) digit_c[DIG_P2_TENS] = BLANK_CODE;
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    idx_inc_c      = idx + DIG_IDX_W'(1);
    value_nxt      = digit_value;
    update_nxt     = '0;
    pend_valid_nxt = pend_valid;
    pend_p1_nxt    = pend_p1;
    pend_p2_nxt    = pend_p2;
    load_c         = 1'b0;
    load_p1_c      = score_p1;
    load_p2_c      = score_p2;
    convert_c      = 1'b0;

    // Requests outside IDLE park in a single overwrite-on-newer slot
    if (score_valid && (state != ST_IDLE)) begin
      pend_valid_nxt = 1'b1;
      pend_p1_nxt    = score_p1;
      pend_p2_nxt    = score_p2;
    end

    case (state)
      ST_IDLE: begin
        if (score_valid || pend_valid) begin
          load_c         = 1'b1;
          pend_valid_nxt = 1'b0;
          if (!score_valid) begin
            load_p1_c = pend_p1;
            load_p2_c = pend_p2;
          end
          state_nxt = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        convert_c = 1'b1;
        if (p1_ready && p2_ready) begin
          idx_nxt   = '0;
          value_nxt = digit_c[DIG_P1_ONES];
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        update_nxt = NUM_DIGITS'(1) << idx;
        state_nxt  = ST_STROBE;
      end
      ST_STROBE: begin
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (idx != DIG_IDX_W'(NUM_DIGITS - 1)) begin
          idx_nxt   = idx_inc_c;
          value_nxt = digit_c[idx_inc_c];
          state_nxt = ST_SETUP;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt == ST_CONVERT) || (state_nxt == ST_SETUP) ||
               (state_nxt == ST_STROBE)  || (state_nxt == ST_HOLD);
    done_nxt = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      digit_value  <= '0;
      digit_update <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pend_valid   <= 1'b0;
      pend_p1      <= '0;
      pend_p2      <= '0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      digit_value  <= value_nxt;
      digit_update <= update_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      pend_valid   <= pend_valid_nxt;
      pend_p1      <= pend_p1_nxt;
      pend_p2      <= pend_p2_nxt;
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: cycle-offset reference model, directed
// scenarios with literal timing expectations, and randomized requests.
module tb_score_display_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       score_valid = 1'b0;
  logic [6:0] score_p1 = '0;
  logic [6:0] score_p2 = '0;

  logic [3:0] dv, dvb, du, dub;
  logic       busy, busyb, done, doneb;

  score_display_ctrl dut (
    .clock(clock), .reset(reset), .score_valid(score_valid),
    .score_p1(score_p1), .score_p2(score_p2),
    .digit_value(dv), .digit_update(du), .busy(busy), .done(done)
  );

  score_display_ctrl #(.BLANK_LEADING(1)) dut_b (
    .clock(clock), .reset(reset), .score_valid(score_valid),
    .score_p1(score_p1), .score_p2(score_p2),
    .digit_value(dvb), .digit_update(dub), .busy(busyb), .done(doneb)
  );

  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: a sequence is described by its start and the
  // offset formulas (SETUP at 2+T+3k, STROBE at 3+T+3k, DONE at 14+T).
  bit m_act = 0, m_pv = 0;
  int m_t = 0, m_T = 0, m_pa = 0, m_pb = 0;
  int m_dig[4], m_digb[4];
  int e_val = 0, e_valb = 0, e_upd = 0;
  bit e_busy = 0, e_done = 0;
  bit rst_s = 0;

  function automatic int sat99(int x);
    return (x > 99) ? 99 : x;
  endfunction

  task automatic m_start(int a, int b);
    int sa, sb;
    sa = sat99(a);
    sb = sat99(b);
    m_dig[0] = sa % 10; m_dig[1] = sa / 10;
    m_dig[2] = sb % 10; m_dig[3] = sb / 10;
    for (int i = 0; i < 4; i++) m_digb[i] = m_dig[i];
    if (m_dig[1] == 0) m_digb[1] = 15;
    if (m_dig[3] == 0) m_digb[3] = 15;
    m_T   = (m_dig[1] > m_dig[3]) ? m_dig[1] : m_dig[3];
    m_act = 1;
    m_t   = 1;
    m_pv  = 0;
  endtask

  always @(posedge clock) begin
    rst_s = reset;
    if (!reset) begin
      m_act = 0; m_pv = 0;
      e_val = 0; e_valb = 0; e_upd = 0; e_busy = 0; e_done = 0;
    end else begin
      if (!m_act) begin
        if (score_valid) m_start(int'(score_p1), int'(score_p2));
        else if (m_pv)   m_start(m_pa, m_pb);
      end else begin
        if (score_valid) begin
          m_pv = 1; m_pa = int'(score_p1); m_pb = int'(score_p2);
        end
        if (m_t == 14 + m_T) m_act = 0;
        else m_t++;
      end
      e_upd = 0; e_busy = 0; e_done = 0;
      if (m_act) begin
        e_busy = (m_t >= 1) && (m_t <= 13 + m_T);
        e_done = (m_t == 14 + m_T);
        if (m_t >= 2 + m_T && m_t <= 13 + m_T) begin
          int k;
          k = (m_t - 2 - m_T) / 3;
          e_val  = m_dig[k];
          e_valb = m_digb[k];
          if ((m_t - 2 - m_T) % 3 == 1) e_upd = 1 << k;
        end
      end
    end
  end

  // Per-cycle comparison plus protocol checks on the strobe bus
  bit       chk_en = 0;
  bit       prev_strobe = 0;
  bit       prev_rst = 1;
  logic [3:0] prev_val = '0;
  logic [3:0] strobe_val = '0;

  always @(negedge clock) begin
    if (chk_en) begin
      check("digit_value", int'(dv), e_val);
      check("digit_value_blank", int'(dvb), e_valb);
      check("digit_update", int'(du), e_upd);
      check("digit_update_blank", int'(dub), e_upd);
      check("busy", int'(busy), int'(e_busy));
      check("busy_blank", int'(busyb), int'(e_busy));
      check("done", int'(done), int'(e_done));
      check("done_blank", int'(doneb), int'(e_done));
      check("update_onehot0", int'($onehot0(du)), 1);
      if (du != '0) check("value_stable_before_strobe", int'(prev_val), int'(dv));
      if (prev_strobe && rst_s) check("value_stable_after_strobe", int'(dv), int'(strobe_val));
      prev_val    = dv;
      prev_strobe = (du != '0);
      strobe_val  = dv;
    end
  end

  // Directed script runner: records strobes/done relative to cycle 0
  int req_n;
  int req_rel[3], req_a[3], req_b[3];
  int s_cyc[$], s_val[$], s_valb[$], d_cyc[$];
  int busy_n;

  task automatic run_script(int len, int rst_at);
    s_cyc.delete(); s_val.delete(); s_valb.delete(); d_cyc.delete();
    busy_n = 0;
    @(negedge clock);
    for (int rel = 0; rel <= len; rel++) begin
      if (rel > 0) @(negedge clock);
      if (du != '0) begin
        s_cyc.push_back(rel); s_val.push_back(int'(dv)); s_valb.push_back(int'(dvb));
      end
      if (done) d_cyc.push_back(rel);
      if (busy) busy_n++;
      if (rst_at >= 0 && rel == rst_at + 1) begin
        check("reset_digit_value", int'(dv), 0);
        check("reset_digit_update", int'(du), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        reset = 1'b1;
      end
      score_valid = 1'b0;
      for (int i = 0; i < req_n; i++) begin
        if (req_rel[i] == rel) begin
          score_valid = 1'b1;
          score_p1 = 7'(req_a[i]);
          score_p2 = 7'(req_b[i]);
        end
      end
      if (rel == rst_at) reset = 1'b0;
    end
    score_valid = 1'b0;
  endtask

  task automatic check_strobes(string tag, int n, int ec[8], int ev[8], bit use_b);
    check({tag, "_strobe_count"}, s_cyc.size(), n);
    for (int i = 0; i < n && i < s_cyc.size(); i++) begin
      check({tag, "_strobe_cycle"}, s_cyc[i], ec[i]);
      check({tag, "_strobe_value"}, use_b ? s_valb[i] : s_val[i], ev[i]);
    end
  endtask

  task automatic check_done(string tag, int n, int c0, int c1);
    check({tag, "_done_count"}, d_cyc.size(), n);
    if (d_cyc.size() > 0) check({tag, "_done_cycle0"}, d_cyc[0], c0);
    if (n > 1 && d_cyc.size() > 1) check({tag, "_done_cycle1"}, d_cyc[1], c1);
  endtask

  task automatic one_req(int a, int b);
    req_n = 1; req_rel[0] = 0; req_a[0] = a; req_b[0] = b;
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("init_digit_value", int'(dv), 0);
    check("init_digit_update", int'(du), 0);
    check("init_busy", int'(busy), 0);
    check("init_done", int'(done), 0);
    chk_en = 1;
    reset  = 1'b1;
    repeat (2) @(negedge clock);

    one_req(37, 5);
    run_script(20, -1);
    check_strobes("s37_5", 4, '{6, 9, 12, 15, 0, 0, 0, 0}, '{7, 3, 5, 0, 0, 0, 0, 0}, 0);
    check_done("s37_5", 1, 17, 0);
    check("s37_5_busy_cycles", busy_n, 16);

    one_req(0, 0);
    run_script(16, -1);
    check_strobes("s0_0_blank", 4, '{3, 6, 9, 12, 0, 0, 0, 0}, '{0, 15, 0, 15, 0, 0, 0, 0}, 1);
    check_strobes("s0_0", 4, '{3, 6, 9, 12, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 0);
    check_done("s0_0", 1, 14, 0);

    one_req(120, 99);
    run_script(26, -1);
    check_strobes("sat", 4, '{12, 15, 18, 21, 0, 0, 0, 0}, '{9, 9, 9, 9, 0, 0, 0, 0}, 0);
    check_done("sat", 1, 23, 0);

    req_n = 3;
    req_rel[0] = 0; req_a[0] = 12; req_b[0] = 34;
    req_rel[1] = 5; req_a[1] = 56; req_b[1] = 78;
    req_rel[2] = 8; req_a[2] = 90; req_b[2] = 11;
    run_script(45, -1);
    check_strobes("b2b", 8, '{6, 9, 12, 15, 30, 33, 36, 39}, '{2, 1, 4, 3, 0, 9, 1, 1}, 0);
    check_done("b2b", 2, 17, 41);
    check("b2b_busy_cycles", busy_n, 38);

    one_req(37, 5);
    run_script(18, 12);
    check_strobes("rst_mid", 3, '{6, 9, 12, 0, 0, 0, 0, 0}, '{7, 3, 5, 0, 0, 0, 0, 0}, 0);
    check("rst_mid_no_done", d_cyc.size(), 0);

    one_req(37, 5);
    run_script(20, -1);
    check_strobes("after_rst", 4, '{6, 9, 12, 15, 0, 0, 0, 0}, '{7, 3, 5, 0, 0, 0, 0, 0}, 0);
    check_done("after_rst", 1, 17, 0);

    // Randomized traffic, including requests while busy and rare resets
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      score_valid = ($urandom_range(0, 7) == 0);
      score_p1    = 7'($urandom_range(0, 127));
      score_p2    = 7'($urandom_range(0, 127));
      reset       = ($urandom_range(0, 199) != 0);
    end
    @(negedge clock);
    score_valid = 1'b0;
    reset       = 1'b1;
    repeat (60) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/score_display_ctrl.md
# score_display_ctrl

Sequencer that feeds player scores to the four seven-segment digit drivers (`Display7Segment`, one per digit) over a shared 4-bit value bus with one-hot update strobes. It accepts two binary scores from the game logic and splits each into tens and ones by sequential repeated subtraction. It then writes the digits to the displays one at a time with setup/strobe/hold spacing, so each driver latches a stable value. It sits between the Pong score registers and the display instances and is the only writer of their `N_in`/`update` inputs.

## Interface
- `SCORE_W`, 7: width of each score input.
- `SCORE_MAX`, 99: saturation limit. Larger inputs display as this value.
- `BLANK_LEADING`, 0: 1 replaces a zero tens digit with `BLANK_CODE`.
- `BLANK_CODE`, 4'hF: code sent for a blanked digit.

- `clock`  in  1  system clock, 50 MHz, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `score_valid`  in  1  one-cycle request to display `score_p1`/`score_p2`.
- `score_p1`  in  SCORE_W  player 1 score, binary.
- `score_p2`  in  SCORE_W  player 2 score, binary.
- `digit_value`  out  4  shared value bus to all digit drivers' `N_in`.
- `digit_update`  out  4  one-hot update strobes. Bit 0 = P1 ones, bit 1 = P1 tens, bit 2 = P2 ones, bit 3 = P2 tens.
- `busy`  out  1  a refresh sequence is in progress.
- `done`  out  1  one-cycle pulse when all four digits have been written.

## Operation
- States:
  - IDLE
  - CONVERT
  - SETUP
  - STROBE
  - HOLD
  - DONE
- IDLE, on request:
  - If `score_valid` is high or `pending` is set, load both scores into the remainders, saturated to `SCORE_MAX`.
  - Clear both tens counts and go to CONVERT.
  - `score_valid` has priority over `pending`. Loading clears `pending`.
- CONVERT, per cycle:
  - For each score independently, if remainder ≥ 10: remainder −= 10, tens += 1.
  - When both remainders are < 10 in the same cycle, set digit index = 0 and go to SETUP.
- SETUP:
  - Drive `digit_value` with the digit selected by the index.
  - If `BLANK_LEADING` is 1 and this is a tens digit equal to 0, drive `BLANK_CODE` instead.
  - All strobes low.
- STROBE: `digit_value` unchanged. `digit_update[index]` is high for exactly one cycle.
- HOLD:
  - All strobes low and `digit_value` unchanged.
  - If index < 3: index += 1 and go to SETUP. Otherwise go to DONE.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- Requests while busy or in DONE:
  - `score_valid` in any state other than IDLE captures both scores into a single pending slot.
  - A newer request overwrites the slot.
  - The running sequence is never aborted or restarted mid-digit.
- Arithmetic: remainders are SCORE_W bits and tens counts are 4 bits. After saturation the tens count never exceeds 9.

## Timing
- Reset values:
  - `digit_value` = 0, `digit_update` = 0, `busy` = 0, `done` = 0.
  - State = IDLE, `pending` cleared.
- Reset asserted mid-sequence: on the next rising edge all outputs take their reset values and the sequence and pending request are discarded.
- All outputs are registered.
- Cycle 0 = cycle in which `score_valid` is sampled high in IDLE. Let T = max(tens digit of P1, tens digit of P2).
  - CONVERT occupies cycles 1 .. 1+T.
  - Digit k: SETUP at 2+T+3k, STROBE at 3+T+3k, HOLD at 4+T+3k.
  - DONE at 14+T.
- `busy` is high from cycle 1 through 13+T and low in DONE.
- Total latency from request to `done` is 14+T cycles, at most 23.
- `digit_value` is stable for at least one full cycle before and after every strobe.
- At most one `digit_update` bit is ever high.
- A pending request starts its CONVERT two cycles after DONE: DONE → IDLE load → CONVERT.

## Structure
- Shared package `pong_display_pkg`:
  - state enum
  - `NUM_DIGITS` = 4
  - digit index constants (`DIG_P1_ONES` … `DIG_P2_TENS`)
  - default `BLANK_CODE`
- Sub-module `score_bcd_split`: one instance per player. It performs load/saturate and the repeated-subtract-by-10 step and outputs `tens`, `ones` and `ready`. The controller waits on both `ready` flags.

## Test plan
- Scores 37/5 at cycle 0:
  - Strobes occur at cycles 6, 9, 12, 15 with `digit_value` 7, 3, 5, 0.
  - `done` pulses at cycle 17.
  - `busy` is high for cycles 1–16.
- Scores 0/0 with `BLANK_LEADING` = 1:
  - Values are 0, F, 0, F, with the strobes at cycles 3, 6, 9, 12.
  - `done` pulses at cycle 14.
- Saturation: score_p1 = 120, score_p2 = 99 → all four digits written as 9, `done` at cycle 23.
- Back-to-back requests:
  - 12/34 at cycle 0, then 56/78 during cycle 5, then 90/11 during cycle 8.
  - The first sequence completes unchanged.
  - The next sequence shows 90/11. 56/78 is never displayed.
- Reset low during the STROBE of digit 2 → the next cycle shows all outputs at 0 and IDLE. A new request afterwards behaves like cycle 0.
- Over all runs: a checker asserts `digit_update` is one-hot or zero, and that `digit_value` is stable from one cycle before to one cycle after each strobe.
